mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 10, giving the word-index width driven to the data memory (1024 words).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request from the EX/MEM register.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 req_signed  input  1  1=sign-extend sub-word loads, 0=zero-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 mem_addr  output  32  word index to data memory, {zeros, addr[ADDR_BITS+1:2]}.
REQ-012 mem_we  output  1  data memory write enable.
REQ-013 mem_wdata  output  32  data memory write data.
REQ-014 mem_rdata  input  32  combinational read data from data memory.
REQ-015 load_valid  output  1  one-cycle pulse, load_data valid.
REQ-016 load_data  output  32  extended load result.
REQ-017 misalign_trap  output  1  one-cycle pulse on misaligned request (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, WRITE; req_ready SHALL equal (state==IDLE).
REQ-019 On accept, address, size, signed, we and wdata SHALL be registered and state SHALL go to ACCESS.
REQ-020 mem_addr SHALL be driven from the registered address; address bits above ADDR_BITS+1 are ignored.
REQ-021 Byte lanes are little-endian: byte k = bits[8k+7:8k] at addr[1:0]=k; halfword at addr[1] uses bits[16*addr[1]+15:16*addr[1]].
REQ-022 Load, ACCESS: selected lane of mem_rdata SHALL be extended and registered into load_data; load_valid SHALL pulse the next cycle; state returns to IDLE (accept cycle N -> load_valid in N+2).
REQ-023 Word store, ACCESS: mem_we=1, mem_wdata=req_wdata for exactly that cycle; state returns to IDLE.
REQ-024 Sub-word store, ACCESS: mem_rdata SHALL be merged with the low byte/half of wdata into the addressed lane, registered, state goes to WRITE, mem_we=0.
REQ-025 Sub-word store, WRITE: mem_we=1, mem_wdata=merged word for exactly one cycle; state returns to IDLE.
REQ-026 mem_we SHALL be 0 in IDLE and in every ACCESS cycle other than a word store.
REQ-027 load_data SHALL hold its value until the next load completes.
REQ-028 Throughput: loads and word stores one per 2 cycles; sub-word stores one per 3 cycles; req_valid while not ready SHALL be ignored.

Reset
REQ-029 While rst is high: state=IDLE, req_ready=1, mem_we=0, load_valid=0, misalign_trap=0, load_data=0, internal address/data registers=0.
REQ-030 Reset asserted in ACCESS or WRITE SHALL drop mem_we immediately and abandon the operation; no partial write.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL be accepted, pass through ACCESS with mem_we=0, produce no load_valid, and pulse misalign_trap in the cycle load_valid would have pulsed.
REQ-032 Macro undefined: misalign_trap SHALL be tied 0; halfword ignores addr[0], word ignores addr[1:0] (forced alignment).

Verification
REQ-033 Word 8 = 0x8899AABB; load byte signed addr 0x21 -> load_valid at N+2, load_data=0xFFFFFFAA.
REQ-034 Same memory; load half unsigned addr 0x22 -> load_data=0x00008899; signed -> 0xFFFF8899.
REQ-035 Store byte addr 0x23 wdata 0x00000011 -> mem_we high exactly one cycle (WRITE) with mem_addr=8, mem_wdata=0x1199AABB; req_ready low 2 cycles.
REQ-036 Store word addr 0x20 wdata 0xDEADBEEF -> mem_we high one cycle in ACCESS, mem_wdata=0xDEADBEEF; next load word 0x20 returns 0xDEADBEEF.
REQ-037 Load half addr 0x21: with LSU_MISALIGN_TRAP_EN -> misalign_trap pulse, no load_valid; without -> load_data=0x0000AABB (unsigned).
REQ-038 Store byte accepted, rst pulsed during WRITE -> mem_we never high, word 8 unchanged, req_ready=1 after reset.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the EX/MEM register and a word-wide data memory.
// Latency: load accept N -> load_valid N+2; word store writes in N+1; sub-word store writes in N+2.
// Backpressure: req_ready only in IDLE; a request offered while busy is ignored.
//
// Ports: clk/rst (async active-high); req_* request in; mem_* word-indexed data memory
// (mem_rdata combinational); load_valid/load_data result; misalign_trap pulse.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word requests instead of
// forcing their alignment.
module mem_access_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

  state_t                 r_state, w_next;
  logic [ADDR_BITS+1:0]   r_addr;
  logic [1:0]             r_size;
  logic                   r_signed;
  logic                   r_we;
  logic [31:0]            r_wdata;
  logic [31:0]            r_merged;
  logic [31:0]            r_load_data;
  logic                   r_load_valid;
  logic                   w_accept;
  logic                   w_misalign;
  logic                   w_subword_store;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [31:0]            w_load_ext;
  logic [31:0]            w_merged;
  logic                   w_unused_addr;

  // Address bits above the memory's reach are deliberately dropped.
  assign w_unused_addr = ^req_addr[31:ADDR_BITS+2];

  assign w_accept = req_valid && (r_state == IDLE);
  assign mem_addr = {{(32-ADDR_BITS){1'b0}}, r_addr[ADDR_BITS+1:2]};

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_trap;
  assign w_misalign = ((r_size == 2'b01) && r_addr[0]) || (r_size[1] && (r_addr[1:0] != 2'b00));
  assign misalign_trap = r_trap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_trap <= 1'b0;
    else     r_trap <= (r_state == ACCESS) && w_misalign;
  end
`else
  assign w_misalign    = 1'b0;
  assign misalign_trap = 1'b0;
`endif

  // Size 11 behaves as a word, so only size[1]==0 is a sub-word access.
  assign w_subword_store = r_we && !r_size[1];

  // Lane extraction and sign/zero extension of the load result.
  always_comb begin
    w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // Read-modify-write merge: insert the low store bits into the addressed lane.
  always_comb begin
    w_merged = mem_rdata;
    if (r_size == 2'b00) w_merged[{r_addr[1:0], 3'b000} +: 8]   = r_wdata[7:0];
    else                 w_merged[{r_addr[1], 4'b0000} +: 16]   = r_wdata[15:0];
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = ACCESS;
      ACCESS:  w_next = (w_subword_store && !w_misalign) ? WRITE : IDLE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM: outputs. Decoded from the async-reset state, so rst drops mem_we at once.
  always_comb begin
    req_ready = (r_state == IDLE);
    mem_we    = 1'b0;
    mem_wdata = r_wdata;
    case (r_state)
      ACCESS:  mem_we = r_we && r_size[1] && !w_misalign;
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = r_merged;
      end
      default: ;
    endcase
  end

  // Request capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_merged     <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      if (w_accept) begin
        r_addr   <= req_addr[ADDR_BITS+1:0];
        r_size   <= req_size;
        r_signed <= req_signed;
        r_we     <= req_we;
        r_wdata  <= req_wdata;
      end
      if (r_state == ACCESS && !w_misalign) begin
        if (!r_we) begin
          r_load_data  <= w_load_ext;
          r_load_valid <= 1'b1;
        end else if (w_subword_store) begin
          r_merged <= w_merged;
        end
      end
    end
  end

  assign load_valid = r_load_valid;
  assign load_data  = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign_trap;

  logic [31:0] mem [0:1023];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .load_valid(load_valid), .load_data(load_data),
    .misalign_trap(misalign_trap)
  );

  // Behavioural data memory: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for one cycle; returns at the falling edge of the ACCESS cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[8]     = 32'h8899AABB;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_lvalid", {31'b0, load_valid}, 32'h0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    rst = 1'b0;

    // Load byte signed 0x21 -> 0xFFFFFFAA at N+2
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    chk("lb_access_ready", {31'b0, req_ready}, 32'h0);
    chk("lb_access_maddr", mem_addr, 32'h8);
    chk("lb_access_we", {31'b0, mem_we}, 32'h0);
    chk("lb_access_lvalid", {31'b0, load_valid}, 32'h0);
    @(negedge clk);
    chk("lb_lvalid", {31'b0, load_valid}, 32'h1);
    chk("lb_data", load_data, 32'hFFFFFFAA);
    chk("lb_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    chk("lb_lvalid_pulse", {31'b0, load_valid}, 32'h0);
    chk("lb_hold", load_data, 32'hFFFFFFAA);

    // Load half unsigned / signed at 0x22
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    @(negedge clk);
    chk("lhu_data", load_data, 32'h00008899);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    @(negedge clk);
    chk("lh_data", load_data, 32'hFFFF8899);

    // Misaligned half at 0x21; upper address bits beyond the memory are ignored
    issue(1'b0, 2'b01, 1'b0, 32'hF000_0021, 32'h0);
    chk("mis_maddr", mem_addr, 32'h8);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_trap", {31'b0, misalign_trap}, 32'h1);
    chk("mis_lvalid", {31'b0, load_valid}, 32'h0);
    chk("mis_hold", load_data, 32'hFFFF8899);
    @(negedge clk);
    chk("mis_trap_pulse", {31'b0, misalign_trap}, 32'h0);
`else
    chk("mis_trap", {31'b0, misalign_trap}, 32'h0);
    chk("mis_lvalid", {31'b0, load_valid}, 32'h1);
    chk("mis_data", load_data, 32'h0000AABB);
`endif

    // Byte store 0x23 <- 0x11: read-modify-write, one write in WRITE
    issue(1'b1, 2'b00, 1'b0, 32'h23, 32'h00000011);
    chk("sb_access_we", {31'b0, mem_we}, 32'h0);
    chk("sb_access_ready", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("sb_write_we", {31'b0, mem_we}, 32'h1);
    chk("sb_write_maddr", mem_addr, 32'h8);
    chk("sb_write_wdata", mem_wdata, 32'h1199AABB);
    chk("sb_write_ready", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("sb_done_we", {31'b0, mem_we}, 32'h0);
    chk("sb_done_ready", {31'b0, req_ready}, 32'h1);
    chk("sb_mem", mem[8], 32'h1199AABB);
    chk("sb_ldata_hold", load_data,
`ifdef LSU_MISALIGN_TRAP_EN
        32'hFFFF8899);
`else
        32'h0000AABB);
`endif

    // Word store 0x20 <- 0xDEADBEEF writes in ACCESS; a request offered while busy is ignored
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
    chk("sw_access_we", {31'b0, mem_we}, 32'h1);
    chk("sw_access_wdata", mem_wdata, 32'hDEADBEEF);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h40;
    req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sw_done_we", {31'b0, mem_we}, 32'h0);
    chk("sw_done_ready", {31'b0, req_ready}, 32'h1);
    chk("busy_ignored", mem[16], 32'h0);

    // Load word back
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("lw_lvalid", {31'b0, load_valid}, 32'h1);
    chk("lw_data", load_data, 32'hDEADBEEF);

    // Size 11 as word, half upper lane at 0x22 of 0xDEADBEEF
    issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("l11_data", load_data, 32'hDEADBEEF);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA5566);
    @(negedge clk);
    chk("sh_wdata", mem_wdata, 32'h5566BEEF);
    @(negedge clk);
    chk("sh_mem", mem[8], 32'h5566BEEF);

    // Reset asserted as the byte store enters WRITE: no write lands
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000055);
    chk("rw_access_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rw_we_dropped", {31'b0, mem_we}, 32'h0);
    chk("rw_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rw_mem", mem[8], 32'h5566BEEF);
    chk("rw_ldata", load_data, 32'h0);
    @(negedge clk);
    chk("rw_ready_after", {31'b0, req_ready}, 32'h1);
    chk("rw_we_after", {31'b0, mem_we}, 32'h0);
    chk("rw_mem_after", mem[8], 32'h5566BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
